// File: rtl/multicycle_rv_core.sv
// ----------------------------------------------------------------------------
// multicycle_rv_core : multi-cycle RV32I-subset integer core (ALU ops only),
//                      FETCH/DECODE/EXECUTE/WRITEBACK with sticky HALT.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module multicycle_rv_core #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int RESET_PC = 0,
  parameter int ADDR_W   = 32
) (
  input  logic              clock,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_valid,
  input  logic [31:0]       imem_rdata,
  output logic              retired,
  output logic              halted,
  output logic [ADDR_W-1:0] pc_out,
  input  logic [4:0]        dbg_sel,
  output logic [XLEN-1:0]   dbg_data
);

  localparam int         RIDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int         SH_W   = $clog2(XLEN);
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] F7_ALT = 7'b0100000;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_WRITEBACK = 3'd3,
    S_HALT      = 3'd4
  } state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] pc;
  logic [31:0]       ir;
  logic [XLEN-1:0]   regs [NUM_REGS];
  logic [XLEN-1:0]   op_a, op_b, result, alu_out;
  logic [3:0]        alu_op, dec_op;
  logic              dec_legal;
  logic [SH_W-1:0]   shamt;
  logic [XLEN-1:0]   imm_sext;
  logic [6:0]        opcode, funct7;
  logic [2:0]        funct3;
  logic [4:0]        rd;

  // Indices beyond the implemented register count read as zero, like x0.
  function automatic logic [XLEN-1:0] reg_read(input logic [4:0] idx);
    if (idx == 5'd0 || 32'(idx) >= NUM_REGS) return '0;
    return regs[idx[RIDX_W-1:0]];
  endfunction

  assign opcode   = ir[6:0];
  assign rd       = ir[11:7];
  assign funct3   = ir[14:12];
  assign funct7   = ir[31:25];
  assign imm_sext = {{(XLEN-12){ir[31]}}, ir[31:20]};

  // alu_op = {alternate-variant bit, funct3}; alternate selects SUB / SRA.
  always_comb begin
    dec_legal = 1'b0;
    dec_op    = {1'b0, funct3};
    if (opcode == OP_R) begin
      dec_op    = {funct7 == F7_ALT, funct3};
      dec_legal = (funct7 == 7'd0) ||
                  (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101));
    end else if (opcode == OP_I) begin
      case (funct3)
        3'b001:  dec_legal = (funct7 == 7'd0);
        3'b101: begin
          dec_legal = (funct7 == 7'd0) || (funct7 == F7_ALT);
          dec_op    = {funct7 == F7_ALT, funct3};
        end
        default: dec_legal = 1'b1;
      endcase
    end
  end

  assign shamt = op_b[SH_W-1:0];

  always_comb begin
    alu_out = op_a + op_b;
    case (alu_op)
      4'b1000: alu_out = op_a - op_b;
      4'b0001: alu_out = op_a << shamt;
      4'b0010: alu_out = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      4'b0011: alu_out = {{(XLEN-1){1'b0}}, op_a < op_b};
      4'b0100: alu_out = op_a ^ op_b;
      4'b0101: alu_out = op_a >> shamt;
      4'b1101: alu_out = $signed(op_a) >>> shamt;
      4'b0110: alu_out = op_a | op_b;
      4'b0111: alu_out = op_a & op_b;
      default: alu_out = op_a + op_b;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:     if (imem_valid) state_next = S_DECODE;
      S_DECODE:    state_next = dec_legal ? S_EXECUTE : S_HALT;
      S_EXECUTE:   state_next = S_WRITEBACK;
      S_WRITEBACK: state_next = S_FETCH;
      S_HALT:      state_next = S_HALT;
      default:     state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc     <= ADDR_W'(RESET_PC);
      ir     <= '0;
      op_a   <= '0;
      op_b   <= '0;
      result <= '0;
      alu_op <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_FETCH: if (imem_valid) ir <= imem_rdata;
        S_DECODE: begin
          op_a   <= reg_read(ir[19:15]);
          op_b   <= (opcode == OP_R) ? reg_read(ir[24:20]) : imm_sext;
          alu_op <= dec_op;
        end
        S_EXECUTE: result <= alu_out;
        S_WRITEBACK: begin
          if (rd != 5'd0 && 32'(rd) < NUM_REGS) regs[rd[RIDX_W-1:0]] <= result;
          pc <= pc + ADDR_W'(4);
        end
        default: ;
      endcase
    end
  end

  assign imem_req  = (state == S_FETCH);
  assign imem_addr = pc;
  assign retired   = (state == S_WRITEBACK);
  assign halted    = (state == S_HALT);
  assign pc_out    = pc;
  assign dbg_data  = reg_read(dbg_sel);

endmodule

`default_nettype wire

// File: tb/tb_multicycle_rv_core.sv
// Bench for multicycle_rv_core: ISA-level reference model checked every cycle,
// plus directed programs with hand-computed register/PC/timing expectations.
`default_nettype none

module tb_multicycle_rv_core;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        retired;
  logic        halted;
  logic [31:0] pc_out;
  logic [4:0]  dbg_sel;
  logic [31:0] dbg_data;

  always #5 clock = ~clock;

  multicycle_rv_core #(.XLEN(32), .NUM_REGS(32), .RESET_PC(0), .ADDR_W(32)) dut (
    .clock(clock), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata), .retired(retired),
    .halted(halted), .pc_out(pc_out), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- reference model (architectural level) ----------------
  logic [31:0] m_regs [32];
  logic [31:0] m_pc;
  logic [31:0] m_ir;
  int          m_age;      // 0: fetching, else cycles since the fetch was accepted
  bit          m_halted;

  function automatic logic [31:0] mread(input logic [4:0] i);
    return (i == 5'd0) ? 32'd0 : m_regs[i];
  endfunction

  function automatic bit legal(input logic [31:0] w);
    logic [6:0] f7;
    logic [2:0] f3;
    f7 = w[31:25];
    f3 = w[14:12];
    if (w[6:0] == 7'h33) return (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
    if (w[6:0] == 7'h13) begin
      if (f3 == 3'd1) return f7 == 7'h00;
      if (f3 == 3'd5) return (f7 == 7'h00) || (f7 == 7'h20);
      return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [31:0] iss(input logic [31:0] w);
    logic [31:0] a, b;
    bit          alt;
    a   = mread(w[19:15]);
    b   = (w[6:0] == 7'h33) ? mread(w[24:20]) : {{20{w[31]}}, w[31:20]};
    alt = w[30] && (w[6:0] == 7'h33 || w[14:12] == 3'd5);
    case (w[14:12])
      3'd0:    return alt ? a - b : a + b;
      3'd1:    return a << b[4:0];
      3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3:    return (a < b) ? 32'd1 : 32'd0;
      3'd4:    return a ^ b;
      3'd5:    return alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  always @(posedge clock) begin
    cyc    <= cyc + 1;
    chk_en <= 1'b1;
    if (reset) begin
      m_pc     <= 32'd0;
      m_age    <= 0;
      m_halted <= 1'b0;
      for (int i = 0; i < 32; i++) m_regs[i] <= 32'd0;
    end else if (!m_halted) begin
      case (m_age)
        0: if (imem_valid) begin m_ir <= imem_rdata; m_age <= 1; end
        1: if (!legal(m_ir)) m_halted <= 1'b1; else m_age <= 2;
        2: m_age <= 3;
        default: begin
          if (m_ir[11:7] != 5'd0) m_regs[m_ir[11:7]] <= iss(m_ir);
          m_pc  <= m_pc + 32'd4;
          m_age <= 0;
        end
      endcase
    end
  end

  // ---------------- per-cycle comparison ----------------
  int n_retire    = 0;
  int last_ret    = 0;
  int last_gap    = 0;

  always @(negedge clock) begin
    if (chk_en) begin
      check("retired",  retired,  !m_halted && m_age == 3);
      check("halted",   halted,   m_halted);
      check("imem_req", imem_req, !m_halted && m_age == 0);
      if (imem_req) check("imem_addr", imem_addr, m_pc);
      check("pc_out",   pc_out,   m_pc);
      check("dbg_data", dbg_data, mread(dbg_sel));
      if (retired) begin
        if (n_retire > 0) last_gap = cyc - last_ret;
        last_ret = cyc;
        n_retire++;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  localparam int TBL_N = 17;
  logic [31:0] t_ins [TBL_N];
  logic [4:0]  t_rd  [TBL_N];
  logic [31:0] t_exp [TBL_N];

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  task automatic wait_fetch();
    int n = 0;
    while (!(imem_req || halted) && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (n >= 50) check("wait_timeout", 0, 1);
  endtask

  // Present one instruction after wt wait cycles; noise drives junk on
  // imem_valid while the core is busy, which must be ignored.
  task automatic fetch(input logic [31:0] ins, input int wt, input bit noise);
    wait_fetch();
    repeat (wt) begin
      #1 imem_valid = 1'b0;
      @(negedge clock);
      check("hold_req", imem_req, 1);
      check("hold_addr", imem_addr, m_pc);
      check("hold_no_retire", retired, 0);
    end
    #1 imem_valid = 1'b1;
    imem_rdata = ins;
    @(negedge clock);
    #1 imem_valid = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    if (noise) begin
      imem_valid = 1'b1;
      imem_rdata = 32'hFFFF_FFFF;
      repeat (2) @(negedge clock);
      #1 imem_valid = 1'b0;
    end
    wait_fetch();
  endtask

  task automatic expect_reg(input logic [4:0] idx, input logic [31:0] exp, input string nm);
    #1 dbg_sel = idx;
    @(negedge clock);
    check(nm, dbg_data, exp);
  endtask

  initial begin
    int ret0;
    reset      = 1'b1;
    imem_valid = 1'b0;
    imem_rdata = 32'd0;
    dbg_sel    = 5'd0;

    t_ins[0]  = enc_r(7'h00, 5'd1, 5'd3, 3'd2, 5'd4);  t_rd[0]  = 5'd4;  t_exp[0]  = 32'd1;
    t_ins[1]  = enc_r(7'h00, 5'd1, 5'd3, 3'd3, 5'd4);  t_rd[1]  = 5'd4;  t_exp[1]  = 32'd0;
    t_ins[2]  = enc_i(12'hFFF, 5'd3, 3'd4, 5'd6);      t_rd[2]  = 5'd6;  t_exp[2]  = 32'd4;
    t_ins[3]  = enc_i(12'h401, 5'd3, 3'd5, 5'd7);      t_rd[3]  = 5'd7;  t_exp[3]  = 32'hFFFF_FFFD;
    t_ins[4]  = enc_i(12'd28,  5'd3, 3'd5, 5'd8);      t_rd[4]  = 5'd8;  t_exp[4]  = 32'h0000_000F;
    t_ins[5]  = enc_i(12'd3,   5'd1, 3'd1, 5'd9);      t_rd[5]  = 5'd9;  t_exp[5]  = 32'd40;
    t_ins[6]  = enc_r(7'h00, 5'd1, 5'd1, 3'd1, 5'd10); t_rd[6]  = 5'd10; t_exp[6]  = 32'd160;
    t_ins[7]  = enc_r(7'h20, 5'd1, 5'd3, 3'd5, 5'd11); t_rd[7]  = 5'd11; t_exp[7]  = 32'hFFFF_FFFF;
    t_ins[8]  = enc_i(12'd0,   5'd3, 3'd2, 5'd12);     t_rd[8]  = 5'd12; t_exp[8]  = 32'd1;
    t_ins[9]  = enc_i(12'hFFF, 5'd1, 3'd3, 5'd13);     t_rd[9]  = 5'd13; t_exp[9]  = 32'd1;
    t_ins[10] = enc_i(12'h0F0, 5'd1, 3'd6, 5'd14);     t_rd[10] = 5'd14; t_exp[10] = 32'h0000_00F5;
    t_ins[11] = enc_i(12'h07F, 5'd3, 3'd7, 5'd15);     t_rd[11] = 5'd15; t_exp[11] = 32'h0000_007B;
    t_ins[12] = enc_r(7'h00, 5'd9, 5'd1, 3'd6, 5'd16); t_rd[12] = 5'd16; t_exp[12] = 32'h0000_002D;
    t_ins[13] = enc_r(7'h00, 5'd9, 5'd3, 3'd7, 5'd17); t_rd[13] = 5'd17; t_exp[13] = 32'h0000_0028;
    t_ins[14] = enc_r(7'h00, 5'd2, 5'd1, 3'd4, 5'd18); t_rd[14] = 5'd18; t_exp[14] = 32'h0000_000F;
    t_ins[15] = enc_r(7'h00, 5'd1, 5'd3, 3'd5, 5'd19); t_rd[15] = 5'd19; t_exp[15] = 32'h07FF_FFFF;
    t_ins[16] = enc_r(7'h00, 5'd3, 5'd3, 3'd0, 5'd20); t_rd[16] = 5'd20; t_exp[16] = 32'hFFFF_FFF6;

    repeat (2) @(posedge clock);
    @(negedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("post_reset_req", imem_req, 1);
    check("post_reset_addr", imem_addr, 0);
    check("post_reset_retired", retired, 0);

    fetch(32'h0050_0093, 0, 1'b0);
    fetch(32'h0010_8133, 0, 1'b0);
    check("retire_count", n_retire, 2);
    check("retire_gap", last_gap, 4);
    check("pc_after_two", pc_out, 8);
    expect_reg(5'd1, 32'd5, "x1_addi");
    expect_reg(5'd2, 32'd10, "x2_add");

    fetch(32'h4010_01B3, 0, 1'b1);
    expect_reg(5'd3, 32'hFFFF_FFFB, "x3_sub");

    for (int i = 0; i < TBL_N; i++) begin
      fetch(t_ins[i], 0, 1'b0);
      expect_reg(t_rd[i], t_exp[i], $sformatf("alu_tbl%0d", i));
    end

    ret0 = n_retire;
    fetch(32'h0070_0013, 0, 1'b0);
    fetch(enc_i(12'd33, 5'd0, 3'd0, 5'd21), 3, 1'b0);
    check("delay_gap", last_gap, 7);
    check("x0_delay_retires", n_retire - ret0, 2);
    check("pc_after_delay", pc_out, 4 * (3 + TBL_N) + 8);
    expect_reg(5'd0, 32'd0, "x0_reads_zero");
    expect_reg(5'd21, 32'd33, "x21_delayed");

    // Reset lands on the edge that would end EXECUTE of addi x5,x0,9.
    ret0 = n_retire;
    wait_fetch();
    #1 imem_valid = 1'b1;
    imem_rdata = 32'h0090_0293;
    @(negedge clock);
    #1 imem_valid = 1'b0;
    @(negedge clock);
    #1 reset = 1'b1;
    repeat (2) @(negedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("reset_mid_no_retire", n_retire - ret0, 0);
    check("reset_mid_pc", pc_out, 0);
    expect_reg(5'd5, 32'd0, "x5_after_reset");

    fetch(32'h0050_0093, 0, 1'b0);
    fetch(32'hFFFF_FFFF, 0, 1'b0);
    check("halted_set", halted, 1);
    for (int i = 0; i < 20; i++) begin
      #1 imem_valid = i[0];
      imem_rdata = 32'h0050_0093;
      @(negedge clock);
      check("halt_req", imem_req, 0);
      check("halt_flag", halted, 1);
      check("halt_pc", pc_out, 4);
    end
    #1 imem_valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("recover_pc", pc_out, 0);
    check("recover_halted", halted, 0);
    check("recover_req", imem_req, 1);
    expect_reg(5'd1, 32'd0, "x1_cleared");

    fetch(32'h0220_8033, 0, 1'b0);
    check("bad_funct7_halts", halted, 1);
    check("bad_funct7_pc", pc_out, 0);

    repeat (2) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
